// File: rtl/regfile_write_buffer_pkg.sv
// rtl/regfile_write_buffer_pkg.sv - shared register-file widths and write-buffer sizing
//   REG_ADDR_LEN : register address width
//   REG_LENGTH   : register data width
//   WB_BUF_DEPTH : write-back buffer depth used by the top-level instance
//   ENABLE/DISABLE : single-bit control levels
package regfile_write_buffer_pkg;

    localparam int REG_ADDR_LEN = 5;
    localparam int REG_LENGTH   = 32;
    localparam int WB_BUF_DEPTH = 4;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/regfile_write_buffer_if.sv
// rtl/regfile_write_buffer_if.sv - write-back request handshake into the write buffer
//   valid : request valid (master -> slave)
//   ready : buffer can accept (slave -> master)
//   addr  : destination register (master -> slave)
//   data  : write value (master -> slave)
interface regfile_write_buffer_if
    import regfile_write_buffer_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_LEN,
    parameter int DATA_W = REG_LENGTH
);

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/regfile_write_buffer.sv
// rtl/regfile_write_buffer.sv - in-order write-back FIFO in front of the RegFile write port with bypass lookup
//   clk, rst           : clock, synchronous active-high reset
//   req (slave)        : write request handshake (valid/ready/addr/data)
//   stall              : hold the head entry this cycle
//   we, wAddr, wData   : RegFile write port, driven from the head entry
//   rdA_*, rdB_*       : bypass lookups, youngest pending value of a register
//   count, empty       : occupancy
module regfile_write_buffer
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH  = WB_BUF_DEPTH,
    parameter int ADDR_W = REG_ADDR_LEN,
    parameter int DATA_W = REG_LENGTH
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_buffer_if.slave   req,
    input  logic                    stall,
    output logic                    we,
    output logic [ADDR_W-1:0]       wAddr,
    output logic [DATA_W-1:0]       wData,
    input  logic [ADDR_W-1:0]       rdA_addr,
    input  logic [ADDR_W-1:0]       rdB_addr,
    output logic                    rdA_hit,
    output logic                    rdB_hit,
    output logic [DATA_W-1:0]       rdA_data,
    output logic [DATA_W-1:0]       rdB_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic accept;
    logic push;
    logic pop;

    // Ready depends only on registered occupancy; a same-cycle pop never
    // reopens a full buffer.
    assign req.ready = (count < CNT_W'(DEPTH));
    assign empty     = (count == '0);

    assign accept = req.valid && req.ready;
    // Writes to $0 complete the handshake but are dropped.
    assign push   = accept && (req.addr != '0);

    assign we    = !empty && !stall;
    assign pop   = we;
    assign wAddr = we ? addr_q[rd_ptr] : '0;
    assign wData = we ? data_q[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_q[wr_ptr] <= req.addr;
            data_q[wr_ptr] <= req.data;
        end
    end

    // Walk entries from oldest (read pointer) to youngest; a later match
    // overwrites an earlier one so the youngest pending value wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        rdA_hit  = 1'b0;
        rdA_data = '0;
        rdB_hit  = 1'b0;
        rdB_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if ((rdA_addr != '0) && (addr_q[idx] == rdA_addr)) begin
                    rdA_hit  = 1'b1;
                    rdA_data = data_q[idx];
                end
                if ((rdB_addr != '0) && (addr_q[idx] == rdB_addr)) begin
                    rdB_hit  = 1'b1;
                    rdB_data = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb/tb_regfile_write_buffer.sv - directed table-driven bench for regfile_write_buffer
module tb_regfile_write_buffer;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        stall;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_ha;
        logic [31:0] e_da;
        logic        e_hb;
        logic [31:0] e_db;
        logic [2:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic we;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wData;
    logic [ADDR_W-1:0] rdA_addr, rdB_addr;
    logic rdA_hit, rdB_hit;
    logic [DATA_W-1:0] rdA_data, rdB_data;
    logic [2:0] count;
    logic empty;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    regfile_write_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_if ();

    regfile_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req_if.slave),
        .stall    (stall),
        .we       (we),
        .wAddr    (wAddr),
        .wData    (wData),
        .rdA_addr (rdA_addr),
        .rdB_addr (rdB_addr),
        .rdA_hit  (rdA_hit),
        .rdB_hit  (rdB_hit),
        .rdA_data (rdA_data),
        .rdB_data (rdB_data),
        .count    (count),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic v, input logic [4:0] a, input logic [31:0] d,
                                input logic s, input logic [4:0] ra, input logic [4:0] rb,
                                input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                                input logic eha, input logic [31:0] eda,
                                input logic ehb, input logic [31:0] edb,
                                input logic [2:0] ecnt, input logic erdy);
        vec_t t;
        t = '{r, v, a, d, s, ra, rb, ewe, ewa, ewd, eha, eda, ehb, edb, ecnt, erdy};
        vecs.push_back(t);
    endfunction

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        rst           = t.rst;
        req_if.valid  = t.vld;
        req_if.addr   = t.addr;
        req_if.data   = t.data;
        stall         = t.stall;
        rdA_addr      = t.ra;
        rdB_addr      = t.rb;
        #1;
        chk(tag, "we",       32'(we),           32'(t.e_we));
        chk(tag, "wAddr",    32'(wAddr),        32'(t.e_wa));
        chk(tag, "wData",    wData,             t.e_wd);
        chk(tag, "rdA_hit",  32'(rdA_hit),      32'(t.e_ha));
        chk(tag, "rdA_data", rdA_data,          t.e_da);
        chk(tag, "rdB_hit",  32'(rdB_hit),      32'(t.e_hb));
        chk(tag, "rdB_data", rdB_data,          t.e_db);
        chk(tag, "count",    32'(count),        32'(t.e_cnt));
        chk(tag, "in_ready", 32'(req_if.ready), 32'(t.e_rdy));
        chk(tag, "empty",    32'(empty),        32'(t.e_cnt == 3'd0));
    endtask

    initial begin
        vec_t t;
        rst = 1'b1;
        req_if.valid = 1'b0;
        req_if.addr  = '0;
        req_if.data  = '0;
        stall    = 1'b0;
        rdA_addr = '0;
        rdB_addr = '0;

        // reset and single write
        add(0,0,0,0,0,             3,0,  0,0,0,               0,0,             0,0,     0,1);
        add(0,1,3,32'h12345678,0,  3,0,  0,0,0,               0,0,             0,0,     0,1);
        add(0,0,0,0,0,             3,0,  1,3,32'h12345678,    1,32'h12345678,  0,0,     1,1);
        add(0,0,0,0,0,             3,0,  0,0,0,               0,0,             0,0,     0,1);
        // zero register
        add(0,1,0,32'hFFFFFFFF,0,  0,0,  0,0,0,               0,0,             0,0,     0,1);
        add(0,0,0,0,0,             0,0,  0,0,0,               0,0,             0,0,     0,1);
        // fill under stall, 5th push refused, pop while full does not reopen ready
        add(0,1,1,32'hA1,1,        0,0,  0,0,0,               0,0,             0,0,     0,1);
        add(0,1,2,32'hA2,1,        1,0,  0,0,0,               1,32'hA1,        0,0,     1,1);
        add(0,1,3,32'hA3,1,        0,0,  0,0,0,               0,0,             0,0,     2,1);
        add(0,1,4,32'hA4,1,        0,0,  0,0,0,               0,0,             0,0,     3,1);
        add(0,1,5,32'hA5,1,        4,5,  0,0,0,               1,32'hA4,        0,0,     4,0);
        add(0,1,6,32'hA6,0,        1,5,  1,1,32'hA1,          1,32'hA1,        0,0,     4,0);
        add(0,0,0,0,0,             0,6,  1,2,32'hA2,          0,0,             0,0,     3,1);
        add(0,0,0,0,0,             0,0,  1,3,32'hA3,          0,0,             0,0,     2,1);
        add(0,0,0,0,0,             0,0,  1,4,32'hA4,          0,0,             0,0,     1,1);
        add(0,0,0,0,0,             6,5,  0,0,0,               0,0,             0,0,     0,1);
        // youngest match
        add(0,1,7,32'h11,1,        0,7,  0,0,0,               0,0,             0,0,     0,1);
        add(0,1,7,32'h22,1,        0,7,  0,0,0,               0,0,             1,32'h11,1,1);
        add(0,0,0,0,1,             0,7,  0,0,0,               0,0,             1,32'h22,2,1);
        add(0,0,0,0,0,             0,7,  1,7,32'h11,          0,0,             1,32'h22,2,1);
        add(0,0,0,0,0,             0,7,  1,7,32'h22,          0,0,             1,32'h22,1,1);
        add(0,0,0,0,0,             0,7,  0,0,0,               0,0,             0,0,     0,1);
        // reset mid-operation (push during reset cycle is also dropped)
        add(0,1,20,32'hC0,1,       0,0,  0,0,0,               0,0,             0,0,     0,1);
        add(0,1,21,32'hC1,1,       0,0,  0,0,0,               0,0,             0,0,     1,1);
        add(0,1,22,32'hC2,1,       0,0,  0,0,0,               0,0,             0,0,     2,1);
        add(1,1,23,32'hC3,1,       20,22,0,0,0,               1,32'hC0,        1,32'hC2,3,1);
        add(0,0,0,0,0,             20,23,0,0,0,               0,0,             0,0,     0,1);
        add(0,0,0,0,0,             21,22,0,0,0,               0,0,             0,0,     0,1);
        add(0,0,0,0,0,             22,20,0,0,0,               0,0,             0,0,     0,1);

        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // back-to-back stream of 10 with the pointers wrapping
        for (int i = 0; i < 10; i++) begin
            if (i == 0)
                t = '{1'b0, 1'b1, 5'(i + 8), 32'(32'hB0 + i), 1'b0, 5'(i + 7), 5'd0,
                      1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1};
            else
                t = '{1'b0, 1'b1, 5'(i + 8), 32'(32'hB0 + i), 1'b0, 5'(i + 7), 5'd0,
                      1'b1, 5'(i + 7), 32'(32'hB0 + i - 1), 1'b1, 32'(32'hB0 + i - 1),
                      1'b0, 32'd0, 3'd1, 1'b1};
            apply(t, $sformatf("stream%0d", i));
        end
        t = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd17, 5'd0,
              1'b1, 5'd17, 32'hB9, 1'b1, 32'hB9, 1'b0, 32'd0, 3'd1, 1'b1};
        apply(t, "stream_tail");
        t = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd17, 5'd0,
              1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1};
        apply(t, "stream_drained");

        for (int i = 22; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
